// File: rtl/voice_arbiter.sv
// voice_arbiter: shares the buzzer pin between the gameover voice and key voices 1..3.
// Gameover has absolute priority; key voices are granted round-robin. Each granted
// tone runs for a fixed duration and drives a square wave at the source's pitch.
// Optional feature macro: SOUND_QUEUE_EN (pending mask for key requests while busy).
// Request semantics: voi1..voi3 are one-cycle pulses, gameover_voi==1 for one cycle is a
// gameover request; there is no back-pressure, a request is consumed on the edge it is seen.
// Debug view: dbg_state encodes IDLE=0, PLAY_KEY=1, PLAY_OVER=2; dbg_rr_ptr is the
// 0-based index of the key voice checked first; dbg_pending is {k3,k2,k1}.
module voice_arbiter #(
  parameter int CNT_W    = 24,
  parameter int KEY_LEN  = 2500000,
  parameter int OVER_LEN = 12500000,
  parameter int DIV_K1   = 47778,
  parameter int DIV_K2   = 37922,
  parameter int DIV_K3   = 31888,
  parameter int DIV_OV   = 63776
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic       voi1,
  input  logic       voi2,
  input  logic       voi3,
  input  logic [1:0] gameover_voi,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] active_src,
  output logic       over_play,
  output logic       tone_done,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_rr_ptr,
  output logic [2:0] dbg_pending
);

`ifdef SOUND_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_LEN - 1);
  localparam logic [CNT_W-1:0] K1_LAST   = CNT_W'(DIV_K1 - 1);
  localparam logic [CNT_W-1:0] K2_LAST   = CNT_W'(DIV_K2 - 1);
  localparam logic [CNT_W-1:0] K3_LAST   = CNT_W'(DIV_K3 - 1);
  localparam logic [CNT_W-1:0] OV_LAST   = CNT_W'(DIV_OV - 1);

  // Durations and half-periods must fit the counters and allow at least two states.
  generate
    if (CNT_W < 2 || CNT_W > 31 ||
        KEY_LEN < 2 || KEY_LEN >= (1 << CNT_W) || OVER_LEN < 2 || OVER_LEN >= (1 << CNT_W) ||
        DIV_K1 < 2 || DIV_K1 >= (1 << CNT_W) || DIV_K2 < 2 || DIV_K2 >= (1 << CNT_W) ||
        DIV_K3 < 2 || DIV_K3 >= (1 << CNT_W) || DIV_OV < 2 || DIV_OV >= (1 << CNT_W)) begin : g_bad_param
      $error("voice_arbiter: LEN/DIV parameters must be >= 2 and < 2**CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY_KEY  = 2'd1,
    PLAY_OVER = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0] hp_cnt;
  logic             phase;
  logic [1:0]       rr_ptr;
  logic [2:0]       pending;

  logic [2:0]       key_req;
  logic             over_req;
  logic [CNT_W-1:0] div_last;
  logic [CNT_W-1:0] dur_last;
  logic [CNT_W-1:0] dur_inc;
  logic [CNT_W-1:0] hp_tick;
  logic             ph_tick;
  logic             dur_end;
  logic             retrig;
  logic [1:0]       served_idx;
  logic [1:0]       next_ptr;
  logic [2:0]       grant_idle;
  logic [2:0]       idle_rest;
  logic [2:0]       cand;
  logic [2:0]       grant_next;
  logic [2:0]       pend_hold;

  // First set bit of mask at or after index start, scanning 0,1,2 with wrap; one-hot result.
  function automatic logic [2:0] pick(input logic [2:0] mask, input logic [1:0] start);
    logic [2:0] g;
    logic [1:0] idx;
    int         s;
    g = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      s = int'(start) + i;
      if (s >= 3) s = s - 3;
      idx = s[1:0];
      if (mask[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  // Request decode, pitch/duration tick values and round-robin selection.
  always_comb begin
    key_req  = {voi3, voi2, voi1};
    over_req = (gameover_voi == 2'd1);
    dur_last = KEY_LAST;
    div_last = K1_LAST;
    if (state == PLAY_OVER) begin
      dur_last = OVER_LAST;
      div_last = OV_LAST;
    end else if (active_src == 3'b010) begin
      div_last = K2_LAST;
    end else if (active_src == 3'b100) begin
      div_last = K3_LAST;
    end
    dur_end    = (dur_cnt == dur_last);
    dur_inc    = dur_cnt + CNT_W'(1);
    hp_tick    = (hp_cnt == div_last) ? '0 : hp_cnt + CNT_W'(1);
    ph_tick    = (hp_cnt == div_last) ? ~phase : phase;
    retrig     = |(key_req & active_src);
    served_idx = (active_src == 3'b100) ? 2'd2 : (active_src == 3'b010) ? 2'd1 : 2'd0;
    next_ptr   = (served_idx == 2'd2) ? 2'd0 : served_idx + 2'd1;
    grant_idle = pick(key_req, rr_ptr);
    idle_rest  = QUEUE_EN ? (key_req & ~grant_idle) : 3'b000;
    // A request from the voice just completing is dropped; other voices stay eligible.
    cand       = QUEUE_EN ? ((pending | key_req) & ~active_src) : 3'b000;
    grant_next = pick(cand, next_ptr);
    pend_hold  = QUEUE_EN ? (pending | (key_req & ~active_src)) : 3'b000;
  end

  // Arbitration FSM with all tone counters and registered outputs.
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      state      <= IDLE;
      dur_cnt    <= '0;
      hp_cnt     <= '0;
      phase      <= 1'b0;
      rr_ptr     <= 2'd0;
      pending    <= 3'b000;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
      active_src <= 3'b000;
      over_play  <= 1'b0;
      tone_done  <= 1'b0;
    end else begin
      tone_done <= 1'b0;
      case (state)
        IDLE: begin
          dur_cnt <= '0;
          hp_cnt  <= '0;
          phase   <= 1'b0;
          buzzer  <= 1'b0;
          if (over_req) begin
            state     <= PLAY_OVER;
            busy      <= 1'b1;
            over_play <= 1'b1;
          end else if (|key_req) begin
            state      <= PLAY_KEY;
            busy       <= 1'b1;
            active_src <= grant_idle;
            pending    <= idle_rest;
          end
        end
        PLAY_KEY: begin
          if (over_req) begin
            state      <= PLAY_OVER;
            active_src <= 3'b000;
            over_play  <= 1'b1;
            pending    <= 3'b000;
            dur_cnt    <= '0;
            hp_cnt     <= '0;
            phase      <= 1'b0;
            buzzer     <= 1'b0;
          end else if (dur_end) begin
            rr_ptr  <= next_ptr;
            dur_cnt <= '0;
            hp_cnt  <= '0;
            phase   <= 1'b0;
            buzzer  <= 1'b0;
            if (|cand) begin
              active_src <= grant_next;
              pending    <= cand & ~grant_next;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              active_src <= 3'b000;
              pending    <= 3'b000;
            end
          end else begin
            dur_cnt   <= retrig ? '0 : dur_inc;
            tone_done <= !retrig && (dur_inc == dur_last);
            hp_cnt    <= hp_tick;
            phase     <= ph_tick;
            buzzer    <= ph_tick & ~mute;
            pending   <= pend_hold;
          end
        end
        PLAY_OVER: begin
          if (dur_end) begin
            dur_cnt <= '0;
            hp_cnt  <= '0;
            phase   <= 1'b0;
            buzzer  <= 1'b0;
            if (!over_req) begin
              state     <= IDLE;
              busy      <= 1'b0;
              over_play <= 1'b0;
            end
          end else begin
            dur_cnt   <= over_req ? '0 : dur_inc;
            tone_done <= !over_req && (dur_inc == dur_last);
            hp_cnt    <= hp_tick;
            phase     <= ph_tick;
            buzzer    <= ph_tick & ~mute;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state   = state;
  assign dbg_rr_ptr  = rr_ptr;
  assign dbg_pending = pending;

endmodule
